data_checker: RTL and testbench
===============================

// Module: data_checker
//
// PURPOSE
//   Receive end of the QSFP integrity stream. Consumes the 256-bit AXI stream from the data
//   generator, after it has crossed the QSFP link. Checks every word against the generator's
//   pattern: 16 lanes of 16 bits, each lane = sequence counter, counter +1 per accepted word.
//   Counts words and errors, and captures the first failing word for debug.
//
// PARAMETERS
//   LANE_W    16   width of one lane; the word is 16 lanes, so TDATA width = 16*LANE_W
//   CNT_W     32   width of word_count / error_count (both saturate at all-ones)
//
// PORTS
//   clock         in   1         sole clock
//   reset         in   1         synchronous, active-high
//   clear         in   1         1-cycle pulse: zero counters, drop capture, return to SYNC
//   AXIS_TDATA    in   16*LANE_W stream data; lane k = TDATA[k*LANE_W +: LANE_W]
//   AXIS_TVALID   in   1         stream valid
//   AXIS_TREADY   out  1         stream ready
//   locked        out  1         1 = expected sequence established (state CHECK)
//   word_count    out  CNT_W     words checked in CHECK state
//   error_count   out  CNT_W     words that failed the check
//   first_err_exp out  LANE_W    expected value at first error
//   first_err_lane0 out LANE_W   lane 0 received at first error
//   first_err_lane1 out LANE_W   lane 1 received at first error
//   first_err_vld out  1         first_err_* hold valid data
//
// BEHAVIOUR
//   - Handshake: word accepted on the rising edge where TVALID & TREADY.
//     TREADY = 0 during reset and the cycle after; then 1 continuously. Never depends on TVALID.
//   - Pipeline: stage 1 registers the accepted word plus a valid flag. Stage 2 compares and
//     updates state/counters. Counters reflect a word 2 clocks after its handshake.
//   - States:
//     SYNC  : the first staged word seeds expected = lane1 + 1 (mod 2^LANE_W); go to CHECK.
//             Counters do not move and the word is not checked.
//     CHECK : a word passes iff all 16 lanes == expected.
//             Pass: word_count++, expected++.
//             Fail: word_count++, error_count++, then resync with expected = lane1 + 1.
//             If first_err_vld == 0, capture expected, lane0 and lane1, and set first_err_vld.
//   - A single bad lane (e.g. lane 0 offset by 1) costs one error per word, not a cascade.
//   - Wrap: expected rolls 0xFFFF -> 0x0000 with no error. Counters saturate, never wrap.
//   - locked = (state == CHECK).
//   - Reset values: state SYNC, TREADY 0, locked 0, counters 0, first_err_* 0.
//   - Reset mid-stream: stage-1 word is discarded, and the next word after reset re-seeds.
//   - clear: same as reset for state, counters and capture, but TREADY stays 1.
//     A word accepted in the clear cycle is dropped from stage 1, and the word after it seeds.
//   - clear while stage 2 would update: clear wins and no count changes.
//   - Gaps (TVALID = 0) stall only; expected is held. There is no timeout.
//
// TESTING
//   1. Reset, then stream 0x0005..0x0104 (all lanes equal). Required: locked=1 after the 1st word,
//      word_count=255, error_count=0, first_err_vld=0.
//   2. Stream from 0xFFFD for 6 words. Required: no errors across the 0xFFFF->0x0000 wrap,
//      word_count=5.
//   3. After lock at 0x0010, give 3 words with lane0 = counter+1 (button held).
//      Required: error_count=3, first_err_exp=0x0011, lane0=0x0012, lane1=0x0011.
//   4. Skip 0x0020 (send 0x1F, 0x21, 0x22). Required: error_count=1, and 0x22 passes
//      (resync worked).
//   5. Random TVALID gaps (50%) over 1000 words. Required: word_count=999, error_count=0,
//      TREADY high throughout.
//   6. Pulse clear mid-stream, and separately pulse reset. Required: counters=0, locked drops
//      then returns one word later, and first_err_vld=0.

Source files
------------

// File: rtl/data_checker.sv
// Receive-side integrity checker for the 256-bit QSFP test stream.
// Stage 1 registers the accepted word; stage 2 compares it, then updates state and counters.
module data_checker #(
  parameter int LANE_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [16*LANE_W-1:0]  AXIS_TDATA,
  input  logic                  AXIS_TVALID,
  output logic                  AXIS_TREADY,
  output logic                  locked,
  output logic [CNT_W-1:0]      word_count,
  output logic [CNT_W-1:0]      error_count,
  output logic [LANE_W-1:0]     first_err_exp,
  output logic [LANE_W-1:0]     first_err_lane0,
  output logic [LANE_W-1:0]     first_err_lane1,
  output logic                  first_err_vld
);

  typedef enum logic {SYNC, CHECK} state_e;

  state_e               state_q, state_d;
  logic                 tready_q;
  logic                 s1_vld_q;
  logic [16*LANE_W-1:0] s1_data_q;
  logic [LANE_W-1:0]    exp_q, exp_d;
  logic [CNT_W-1:0]     wc_q, wc_d;
  logic [CNT_W-1:0]     ec_q, ec_d;
  logic                 fv_q, fv_d;
  logic [LANE_W-1:0]    fexp_q, fexp_d;
  logic [LANE_W-1:0]    fl0_q, fl0_d;
  logic [LANE_W-1:0]    fl1_q, fl1_d;

  logic                 hs;
  logic [LANE_W-1:0]    lane0;
  logic [LANE_W-1:0]    lane1;
  logic [LANE_W-1:0]    reseed;
  logic [15:0]          lane_ok;
  logic                 match;

  assign hs     = AXIS_TVALID & tready_q;
  assign lane0  = s1_data_q[0 +: LANE_W];
  assign lane1  = s1_data_q[LANE_W +: LANE_W];
  assign reseed = lane1 + 1'b1;

  always_comb begin
    lane_ok = '0;
    for (int k = 0; k < 16; k++) begin
      lane_ok[k] = (s1_data_q[k*LANE_W +: LANE_W] == exp_q);
    end
  end

  assign match = &lane_ok;

  // Ready is low in the reset cycle and the one after, then held high.
  always_ff @(posedge clock) begin
    if (reset) begin
      tready_q <= 1'b0;
      s1_vld_q <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      s1_vld_q <= hs & ~clear;
    end
  end

  always_ff @(posedge clock) begin
    if (hs) begin
      s1_data_q <= AXIS_TDATA;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    wc_d    = wc_q;
    ec_d    = ec_q;
    fv_d    = fv_q;
    fexp_d  = fexp_q;
    fl0_d   = fl0_q;
    fl1_d   = fl1_q;
    if (clear) begin
      state_d = SYNC;
      wc_d    = '0;
      ec_d    = '0;
      fv_d    = 1'b0;
      fexp_d  = '0;
      fl0_d   = '0;
      fl1_d   = '0;
    end else if (s1_vld_q) begin
      unique case (state_q)
        SYNC: begin
          exp_d   = reseed;
          state_d = CHECK;
        end
        CHECK: begin
          if (wc_q != '1) wc_d = wc_q + 1'b1;
          if (match) begin
            exp_d = exp_q + 1'b1;
          end else begin
            if (ec_q != '1) ec_d = ec_q + 1'b1;
            exp_d = reseed;
            if (!fv_q) begin
              fv_d   = 1'b1;
              fexp_d = exp_q;
              fl0_d  = lane0;
              fl1_d  = lane1;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SYNC;
      exp_q   <= '0;
      wc_q    <= '0;
      ec_q    <= '0;
      fv_q    <= 1'b0;
      fexp_q  <= '0;
      fl0_q   <= '0;
      fl1_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      wc_q    <= wc_d;
      ec_q    <= ec_d;
      fv_q    <= fv_d;
      fexp_q  <= fexp_d;
      fl0_q   <= fl0_d;
      fl1_q   <= fl1_d;
    end
  end

  assign AXIS_TREADY     = tready_q;
  assign locked          = (state_q == CHECK);
  assign word_count      = wc_q;
  assign error_count     = ec_q;
  assign first_err_vld   = fv_q;
  assign first_err_exp   = fexp_q;
  assign first_err_lane0 = fl0_q;
  assign first_err_lane1 = fl1_q;

endmodule

// File: tb/tb_data_checker.sv
// Directed and randomized bench for data_checker.
// A word-level reference model tracks lock, expected value, counters and first-error capture.
module tb_data_checker;

  localparam int LW = 16;
  localparam int W  = 16 * LW;
  localparam int CW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear;
  logic [W-1:0]  AXIS_TDATA;
  logic          AXIS_TVALID;
  logic          AXIS_TREADY;
  logic          locked;
  logic [CW-1:0] word_count;
  logic [CW-1:0] error_count;
  logic [LW-1:0] first_err_exp;
  logic [LW-1:0] first_err_lane0;
  logic [LW-1:0] first_err_lane1;
  logic          first_err_vld;

  data_checker #(.LANE_W(LW), .CNT_W(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .AXIS_TDATA     (AXIS_TDATA),
    .AXIS_TVALID    (AXIS_TVALID),
    .AXIS_TREADY    (AXIS_TREADY),
    .locked         (locked),
    .word_count     (word_count),
    .error_count    (error_count),
    .first_err_exp  (first_err_exp),
    .first_err_lane0(first_err_lane0),
    .first_err_lane1(first_err_lane1),
    .first_err_vld  (first_err_vld)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          m_lock;
  logic [15:0] m_exp;
  int unsigned m_wc, m_ec;
  bit          m_fv;
  logic [15:0] m_fexp, m_fl0, m_fl1;

  bit mon_en = 0;
  int tready_low = 0;

  always @(negedge clock) begin
    if (mon_en && AXIS_TREADY !== 1'b1) tready_low++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic [15:0] v);
    return {16{v}};
  endfunction

  task automatic model_reset();
    m_lock = 0; m_exp = '0; m_wc = 0; m_ec = 0;
    m_fv = 0; m_fexp = '0; m_fl0 = '0; m_fl1 = '0;
  endtask

  task automatic model_word(input logic [W-1:0] d);
    bit ok;
    logic [15:0] l0, l1;
    l0 = d[15:0];
    l1 = d[31:16];
    if (!m_lock) begin
      m_lock = 1;
      m_exp = l1 + 16'd1;
    end else begin
      ok = 1;
      for (int k = 0; k < 16; k++)
        if (d[k*16 +: 16] != m_exp) ok = 0;
      if (m_wc != 32'hFFFF_FFFF) m_wc++;
      if (ok) begin
        m_exp = m_exp + 16'd1;
      end else begin
        if (m_ec != 32'hFFFF_FFFF) m_ec++;
        if (!m_fv) begin
          m_fv = 1; m_fexp = m_exp; m_fl0 = l0; m_fl1 = l1;
        end
        m_exp = l1 + 16'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input bit apply);
    int n;
    n = 0;
    while (AXIS_TREADY !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("tready_timeout", {63'd0, AXIS_TREADY}, 64'd1);
    AXIS_TDATA  = d;
    AXIS_TVALID = 1'b1;
    tick();
    AXIS_TVALID = 1'b0;
    if (apply) model_word(d);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
  endtask

  task automatic check_all(input string t);
    AXIS_TVALID = 1'b0;
    repeat (3) tick();
    chk({t, ".locked"},  {63'd0, locked},        {63'd0, m_lock});
    chk({t, ".wc"},      {32'd0, word_count},    {32'd0, m_wc});
    chk({t, ".ec"},      {32'd0, error_count},   {32'd0, m_ec});
    chk({t, ".fvld"},    {63'd0, first_err_vld}, {63'd0, m_fv});
    chk({t, ".fexp"},    {48'd0, first_err_exp}, {48'd0, m_fexp});
    chk({t, ".flane0"},  {48'd0, first_err_lane0}, {48'd0, m_fl0});
    chk({t, ".flane1"},  {48'd0, first_err_lane1}, {48'd0, m_fl1});
  endtask

  initial begin
    logic [15:0] v;
    logic [W-1:0] d;
    int r;

    reset = 1'b1; clear = 1'b0;
    AXIS_TVALID = 1'b0; AXIS_TDATA = '0;
    model_reset();
    repeat (3) tick();
    chk("rst.tready", {63'd0, AXIS_TREADY}, 64'd0);
    check_all("rst");
    reset = 1'b0;
    tick();

    // 1: 0x0005..0x0104
    send(mk(16'h0005), 1);
    tick();
    chk("t1.lock_first", {63'd0, locked}, 64'd1);
    for (int i = 6; i <= 16'h0104; i++) send(mk(16'(i)), 1);
    check_all("t1");
    chk("t1.wc255", {32'd0, word_count}, 64'd255);

    // 2: wrap
    pulse_clear();
    for (int i = 0; i < 6; i++) send(mk(16'hFFFD + 16'(i)), 1);
    check_all("t2");
    chk("t2.wc5", {32'd0, word_count}, 64'd5);
    chk("t2.ec0", {32'd0, error_count}, 64'd0);

    // 3: lane0 offset by one
    pulse_clear();
    for (int i = 16'h0E; i <= 16'h10; i++) send(mk(16'(i)), 1);
    for (int i = 16'h11; i <= 16'h13; i++) begin
      d = mk(16'(i));
      d[15:0] = 16'(i) + 16'd1;
      send(d, 1);
    end
    check_all("t3");
    chk("t3.ec3",   {32'd0, error_count},     64'd3);
    chk("t3.fexp",  {48'd0, first_err_exp},   64'h11);
    chk("t3.fl0",   {48'd0, first_err_lane0}, 64'h12);
    chk("t3.fl1",   {48'd0, first_err_lane1}, 64'h11);

    // 4: skipped word, resync
    pulse_clear();
    send(mk(16'h1E), 1);
    send(mk(16'h1F), 1);
    send(mk(16'h21), 1);
    send(mk(16'h22), 1);
    check_all("t4");
    chk("t4.ec1", {32'd0, error_count}, 64'd1);
    chk("t4.wc3", {32'd0, word_count},  64'd3);

    // 5: random gaps
    pulse_clear();
    tready_low = 0;
    mon_en = 1;
    v = 16'($urandom);
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(1) == 1) tick();
      send(mk(v), 1);
      v = v + 16'd1;
    end
    check_all("t5");
    mon_en = 0;
    chk("t5.wc999", {32'd0, word_count}, 64'd999);
    chk("t5.tready", 64'(tready_low), 64'd0);

    // random corruption and skips
    pulse_clear();
    v = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      d = mk(v);
      r = $urandom_range(9);
      if (r == 0) begin
        int k;
        k = $urandom_range(15);
        d[k*16 +: 16] = d[k*16 +: 16] ^ 16'($urandom_range(65535, 1));
      end else if (r == 1) begin
        v = v + 16'd1;
        d = mk(v);
      end
      if ($urandom_range(3) == 0) tick();
      send(d, 1);
      v = v + 16'd1;
    end
    check_all("rnd");

    // 6a: clear mid-stream
    pulse_clear();
    v = 16'h4000;
    send(mk(v), 1);
    d = mk(v + 16'd1);
    d[31:16] = 16'h0;
    send(d, 1);
    v = 16'h0001;
    send(mk(v), 1);
    send(mk(v + 16'd1), 0);
    clear = 1'b1;
    send(mk(v + 16'd2), 0);
    clear = 1'b0;
    model_reset();
    chk("t6c.locked", {63'd0, locked},        64'd0);
    chk("t6c.wc",     {32'd0, word_count},    64'd0);
    chk("t6c.ec",     {32'd0, error_count},   64'd0);
    chk("t6c.fvld",   {63'd0, first_err_vld}, 64'd0);
    send(mk(v + 16'd3), 1);
    chk("t6c.unlocked", {63'd0, locked}, 64'd0);
    tick();
    chk("t6c.relock", {63'd0, locked}, 64'd1);
    for (int i = 4; i < 10; i++) send(mk(v + 16'(i)), 1);
    check_all("t6c");

    // 6b: reset mid-stream
    v = 16'h7000;
    send(mk(v), 1);
    send(mk(v + 16'd2), 1);
    send(mk(v + 16'd3), 0);
    reset = 1'b1;
    send(mk(v + 16'd4), 0);
    reset = 1'b0;
    model_reset();
    chk("t6r.tready", {63'd0, AXIS_TREADY},   64'd0);
    chk("t6r.locked", {63'd0, locked},        64'd0);
    chk("t6r.wc",     {32'd0, word_count},    64'd0);
    chk("t6r.ec",     {32'd0, error_count},   64'd0);
    chk("t6r.fvld",   {63'd0, first_err_vld}, 64'd0);
    send(mk(v + 16'd5), 1);
    tick();
    chk("t6r.relock", {63'd0, locked}, 64'd1);
    for (int i = 6; i < 12; i++) send(mk(v + 16'(i)), 1);
    check_all("t6r");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
